reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Ordered reset-release controller for multiple downstream reset domains in one clock domain.
- Takes the raw board reset, passes it through an internal NRST_SYNCHRONIZER instance, holds all outputs for a fixed time, then releases them one by one with a fixed spacing.
- Also accepts a synchronous soft-reset request that re-runs the sequence.
- Sits at the top of each clock domain, feeding the NRST_I of every block in that domain.

Parameters:
- SYNC_STAGES, 3: flop stages of the internal NRST_SYNCHRONIZER; legal values ≥2.
- N_OUT, 4: number of sequenced reset outputs; legal values ≥1.
- HOLD_CYCLES, 16: cycles all outputs stay asserted after the synchronized reset deasserts; legal values ≥1.
- STEP_CYCLES, 8: cycles between consecutive output releases; legal values ≥1.

Ports:
- CLK_I  input  1  system clock; all logic on rising edge.
- NRST_I  input  1  raw reset; asynchronous, active-low (already decided).
- SRST_REQ_I  input  1  soft-reset request; synchronous to CLK_I, single-cycle pulse or level.
- NRST_O  output  N_OUT  sequenced active-low resets; bit 0 is released first.
- BUSY_O  output  1  high while the sequence is in progress (HOLD or RELEASE).
- DONE_O  output  1  high once all NRST_O bits are released (RUN).

Behaviour:
- Internal reset: nrst_s is the NRST_SYNCHRONIZER output.
  - Assertion is asynchronous.
  - Deassertion occurs SYNC_STAGES edges after NRST_I rises.
  - All FSM flops use nrst_s as their asynchronous active-low reset.
- Reset values (nrst_s=0):
  - NRST_O = all zeros, BUSY_O = 1, DONE_O = 0.
  - state = HOLD, cnt = 0, idx = 0.
- Counter width is $clog2(max(HOLD_CYCLES,STEP_CYCLES)+1). idx width is max(1,$clog2(N_OUT)).
- FSM states are HOLD, RELEASE and RUN; all outputs are registered.
- HOLD:
  - cnt increments every edge.
  - On the edge where cnt==HOLD_CYCLES-1: NRST_O[0] <= 1, cnt <= 0, idx <= 1.
  - Same edge: if N_OUT==1, go to RUN; otherwise go to RELEASE.
- RELEASE:
  - cnt increments every edge.
  - On the edge where cnt==STEP_CYCLES-1: NRST_O[idx] <= 1, cnt <= 0, idx <= idx+1.
  - If idx==N_OUT-1 on that edge, go to RUN.
- RUN:
  - BUSY_O = 0, DONE_O = 1, NRST_O = all ones.
  - Outputs are held until a soft request or reset.
- Release timing, counted in rising edges after nrst_s rises:
  - NRST_O[k] rises at edge HOLD_CYCLES + k*STEP_CYCLES.
  - DONE_O rises on the same edge as NRST_O[N_OUT-1].
  - Defaults: 16, 24, 32, 40.
- NRST_O bits are monotonic during a sequence: a released bit never re-asserts except through a soft request or reset.
- Soft request: SRST_REQ_I=1 sampled in RELEASE or RUN causes, on that edge:
  - NRST_O <= 0, cnt <= 0, idx <= 0, state <= HOLD.
  - BUSY_O <= 1, DONE_O <= 0.
  - The full sequence then restarts.
- SRST_REQ_I is ignored in HOLD. A level held high therefore keeps restarting the sequence each time it leaves HOLD, which is legal and intended.
- Simultaneous events:
  - SRST_REQ_I on the same edge as a release step: the request wins and no bit is released.
  - SRST_REQ_I on the same edge as the HOLD terminal count: the request is ignored, because the FSM is still in HOLD.
- Reset mid-operation: NRST_I low in any state forces all outputs to their reset values within the same time step, with no clock needed.
- Glitches on NRST_I shorter than one clock still assert outputs. The sequence then restarts from HOLD after the synchronized release.
- No combinational path from any input to NRST_O except the asynchronous reset.

Decomposition:
- Package rst_seq_pkg holds:
  - typedef enum logic [1:0] {HOLD, RELEASE, RUN} rst_seq_state_t.
  - A function cnt_width(hold, step) returning the counter width.
- One sub-module: NRST_SYNCHRONIZER, parameterised with STAGES=SYNC_STAGES.
- The FSM, counter and output register stay in reset_sequencer. No further split.
- Parameter legality is checked with elaboration-time assertions.

Test Plan:
- Power-up (defaults, 4 ns clock period): NRST_I=0 until 1 ns, then 1.
  - NRST_O = 4'b0000, BUSY_O = 1, DONE_O = 0 throughout the hold.
  - NRST_O[0..3] rise exactly 16, 24, 32, 40 edges after nrst_s rises.
  - DONE_O rises with NRST_O[3], and BUSY_O falls on the same edge.
- Async assert mid-RELEASE: drop NRST_I with NRST_O = 4'b0011, between clock edges.
  - NRST_O = 0, BUSY_O = 1 and DONE_O = 0 immediately, before the next edge.
  - On NRST_I re-release, the sequence replays with identical timing.
- Soft request in RUN: one-cycle SRST_REQ_I pulse.
  - Next edge: NRST_O = 0, DONE_O = 0.
  - NRST_O[0] rises 16 edges after the request edge; DONE_O rises at +40.
- Request colliding with a release: pulse SRST_REQ_I on the edge where NRST_O[2] would rise.
  - NRST_O[2] never rises and NRST_O clears to 0.
  - A second pulse during the next HOLD has no effect on timing.
- Parameter sweep: N_OUT=1, HOLD_CYCLES=1, STEP_CYCLES=1.
  - NRST_O[0] and DONE_O rise on the first edge after nrst_s rises.
  - SRST_REQ_I held high produces a 0/1 toggle of NRST_O with period 2 edges.
- Sub-cycle glitch: NRST_I low for 1 ns while in RUN.
  - Outputs assert asynchronously.
  - The sequence restarts, and DONE_O returns after SYNC_STAGES+40 edges.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the ordered reset-release controller.
package rst_seq_pkg;

    // Sequencer phases: hold everything, release one by one, then run.
    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } rst_seq_state_t;

    // The counter must be able to hold the larger of the two terminal counts.
    function automatic int cnt_width(input int hold, input int step);
        int m;
        m = (hold > step) ? hold : step;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/NRST_SYNCHRONIZER.sv
// Active-low reset synchronizer: asserts asynchronously, deasserts after
// STAGES rising edges of the clock once the raw reset has gone high.
module NRST_SYNCHRONIZER #(
    parameter int STAGES = 3
) (
    input  logic i_clk,
    input  logic i_nrst,
    output logic o_nrst
);

    if (STAGES < 2) begin : g_bad_stages
        $error("NRST_SYNCHRONIZER: STAGES must be at least 2");
    end

    logic [STAGES-1:0] r_sync;

    // Shift ones in behind the released raw reset; any low pulse clears the chain.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], 1'b1};
        end
    end

    assign o_nrst = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: holds all downstream resets for a fixed
// time after the synchronized reset releases, then frees them one at a time.
// A synchronous soft request from RELEASE or RUN re-runs the whole sequence.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int N_OUT       = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic             CLK_I,
    input  logic             NRST_I,
    input  logic             SRST_REQ_I,
    output logic [N_OUT-1:0] NRST_O,
    output logic             BUSY_O,
    output logic             DONE_O
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STEP_CYCLES);
    localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be at least 2");
    end
    if (N_OUT < 1) begin : g_bad_nout
        $error("reset_sequencer: N_OUT must be at least 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (STEP_CYCLES < 1) begin : g_bad_step
        $error("reset_sequencer: STEP_CYCLES must be at least 1");
    end

    logic w_nrst_s;

    rst_seq_state_t   r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [N_OUT-1:0] r_nrst, w_nrst_next;
    logic             r_busy, w_busy_next;
    logic             r_done, w_done_next;

    NRST_SYNCHRONIZER #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk  (CLK_I),
        .i_nrst (NRST_I),
        .o_nrst (w_nrst_s)
    );

    // State, counters and registered outputs; all cleared by the synchronized reset.
    always_ff @(posedge CLK_I or negedge w_nrst_s) begin
        if (!w_nrst_s) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_nrst  <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_nrst  <= w_nrst_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state and next-output logic; a soft request outranks a release step.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_nrst_next  = r_nrst;
        w_busy_next  = r_busy;
        w_done_next  = r_done;

        case (r_state)
            HOLD: begin
                // Soft requests are deliberately ignored while holding.
                if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    w_nrst_next = r_nrst | N_OUT'(1);
                    w_cnt_next  = '0;
                    w_idx_next  = IDX_W'(1);
                    if (N_OUT == 1) begin
                        w_state_next = RUN;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = RELEASE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (SRST_REQ_I) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_nrst_next  = '0;
                    w_busy_next  = 1'b1;
                    w_done_next  = 1'b0;
                end else if (r_cnt == CNT_W'(STEP_CYCLES - 1)) begin
                    for (int k = 0; k < N_OUT; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            w_nrst_next[k] = 1'b1;
                        end
                    end
                    w_cnt_next = '0;
                    w_idx_next = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(N_OUT - 1)) begin
                        w_state_next = RUN;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end

            RUN: begin
                if (SRST_REQ_I) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_nrst_next  = '0;
                    w_busy_next  = 1'b1;
                    w_done_next  = 1'b0;
                end else begin
                    w_nrst_next = '1;
                    w_busy_next = 1'b0;
                    w_done_next = 1'b1;
                end
            end

            default: begin
                w_state_next = HOLD;
                w_cnt_next   = '0;
                w_idx_next   = '0;
                w_nrst_next  = '0;
                w_busy_next  = 1'b1;
                w_done_next  = 1'b0;
            end
        endcase
    end

    assign NRST_O = r_nrst;
    assign BUSY_O = r_busy;
    assign DONE_O = r_done;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal
// N_OUT=1 / HOLD=1 / STEP=1 instance, checked edge by edge.
module tb_reset_sequencer;

    logic       clk;
    logic       nrst;
    logic       srst;
    logic [3:0] nrst_o;
    logic       busy;
    logic       done;

    logic       nrst2;
    logic       srst2;
    logic [0:0] nrst2_o;
    logic       busy2;
    logic       done2;

    int n_checks = 0;
    int n_errors = 0;

    reset_sequencer #(
        .SYNC_STAGES (3),
        .N_OUT       (4),
        .HOLD_CYCLES (16),
        .STEP_CYCLES (8)
    ) dut (
        .CLK_I      (clk),
        .NRST_I     (nrst),
        .SRST_REQ_I (srst),
        .NRST_O     (nrst_o),
        .BUSY_O     (busy),
        .DONE_O     (done)
    );

    reset_sequencer #(
        .SYNC_STAGES (3),
        .N_OUT       (1),
        .HOLD_CYCLES (1),
        .STEP_CYCLES (1)
    ) dut_min (
        .CLK_I      (clk),
        .NRST_I     (nrst2),
        .SRST_REQ_I (srst2),
        .NRST_O     (nrst2_o),
        .BUSY_O     (busy2),
        .DONE_O     (done2)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    // Compare one observed value against its expectation.
    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {busy, done, nrst[3:0]} s edges after the sequence start edge
    // (HOLD=16, STEP=8): bit k is free from edge 16+8k, done from edge 40.
    function automatic logic [5:0] exp_vec(input int s);
        logic [3:0] n;
        logic       d;
        for (int k = 0; k < 4; k++) begin
            n[k] = (s >= 16 + 8 * k);
        end
        d = (s >= 40);
        return {~d, d, n};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {2'b00, busy, done, nrst_o};
    endfunction

    // Walk edges first_e..last_e, checking the default instance after each edge.
    task automatic run_seq(input int first_e, input int last_e, input int offset, input string name);
        for (int e = first_e; e <= last_e; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("%s_e%0d", name, e), obs_vec(), {2'b00, exp_vec(e - offset)});
        end
    endtask

    initial begin
        nrst  = 1'b1;
        nrst2 = 1'b1;
        srst  = 1'b0;
        srst2 = 1'b0;

        // Let the synchronizers come up so the reset drop below is a real edge.
        repeat (5) @(posedge clk);
        #1;
        nrst  = 1'b0;
        nrst2 = 1'b0;
        #1;
        check_eq("reset_state", obs_vec(), 8'b0010_0000);
        check_eq("reset_state_min", {5'b0, busy2, done2, nrst2_o}, 8'b0000_0100);
        #1;
        nrst = 1'b1;
        run_seq(1, 45, 3, "pwr");
        $display("power-up sequence: checks=%0d errors=%0d", n_checks, n_errors);

        // Async assert in RELEASE while NRST_O = 0011, then replay.
        nrst = 1'b0;
        #1;
        nrst = 1'b1;
        run_seq(1, 29, 3, "pre_async");
        check_eq("pre_async_0011", {4'b0, nrst_o}, 8'h03);
        nrst = 1'b0;
        #1;
        check_eq("async_assert", obs_vec(), 8'b0010_0000);
        nrst = 1'b1;
        run_seq(1, 45, 3, "replay");
        $display("async assert mid-release: checks=%0d errors=%0d", n_checks, n_errors);

        // One-cycle soft request from RUN.
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        check_eq("soft_run_clear", obs_vec(), {2'b00, exp_vec(0)});
        run_seq(1, 42, 0, "soft");
        $display("soft request in RUN: checks=%0d errors=%0d", n_checks, n_errors);

        // Restart, then collide a request with the NRST_O[2] release edge.
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        run_seq(1, 31, 0, "pre_collide");
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        check_eq("collide_bit2", {7'b0, nrst_o[2]}, 8'h00);
        check_eq("collide_clear", obs_vec(), {2'b00, exp_vec(0)});
        run_seq(1, 5, 0, "hold_a");
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        check_eq("hold_ignore_e6", obs_vec(), {2'b00, exp_vec(6)});
        run_seq(7, 42, 0, "hold_b");
        $display("request collision: checks=%0d errors=%0d", n_checks, n_errors);

        // 1-unit glitch on the raw reset while in RUN.
        nrst = 1'b0;
        #1;
        check_eq("glitch_assert", obs_vec(), 8'b0010_0000);
        nrst = 1'b1;
        run_seq(1, 45, 3, "glitch");
        $display("sub-cycle glitch: checks=%0d errors=%0d", n_checks, n_errors);

        // Minimal instance: release on the first edge after nrst_s rises.
        nrst2 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("min_pwr_e%0d", e), {5'b0, busy2, done2, nrst2_o},
                     (e >= 4) ? 8'b0000_0011 : 8'b0000_0100);
        end
        // Held request toggles NRST_O with a period of two edges.
        srst2 = 1'b1;
        for (int e = 6; e <= 13; e++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("min_toggle_e%0d", e), {5'b0, busy2, done2, nrst2_o},
                     (e % 2 == 1) ? 8'b0000_0011 : 8'b0000_0100);
        end
        srst2 = 1'b0;
        $display("minimal parameter set: checks=%0d errors=%0d", n_checks, n_errors);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
